// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction type/function
// codes, PC source and ALU operation selects, and the decoded instruction class.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_J = 2'b01;
    localparam logic [1:0] TYPE_I = 2'b10;
    localparam logic [1:0] TYPE_S = 2'b11;

    localparam logic [4:0] FR_AND  = 5'd0;
    localparam logic [4:0] FR_ADD  = 5'd1;
    localparam logic [4:0] FR_SUB  = 5'd2;
    localparam logic [4:0] FR_CMP  = 5'd3;
    localparam logic [4:0] FJ_J    = 5'd0;
    localparam logic [4:0] FJ_JAL  = 5'd1;
    localparam logic [4:0] FI_ANDI = 5'd0;
    localparam logic [4:0] FI_ADDI = 5'd1;
    localparam logic [4:0] FI_LW   = 5'd2;
    localparam logic [4:0] FI_SW   = 5'd3;
    localparam logic [4:0] FI_BEQ  = 5'd4;
    localparam logic [4:0] FS_SLL  = 5'd0;
    localparam logic [4:0] FS_SLR  = 5'd1;
    localparam logic [4:0] FS_SLLV = 5'd2;
    localparam logic [4:0] FS_SLRV = 5'd3;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_STACK  = 2'd3
    } pc_src_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_SLL = 3'd3,
        ALU_SLR = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        CL_ALU = 3'd0,
        CL_LW  = 3'd1,
        CL_SW  = 3'd2,
        CL_BEQ = 3'd3,
        CL_J   = 3'd4,
        CL_JAL = 3'd5
    } class_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> decoder/datapath signal bundle. The master side is the controller;
// the slave side is the decoder, datapath, memory and return stack.
interface multicycle_control_if;
    logic [1:0] Type;
    logic [4:0] Func;
    logic       Stop;
    logic       zero;
    logic       mem_ready;
    logic       stack_full;
    logic       stack_empty;
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       shamt_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       wb_mem;
    logic       push;
    logic       pop;
    logic       illegal;

    modport master (
        input  Type, Func, Stop, zero, mem_ready, stack_full, stack_empty,
        output state, ir_write, pc_write, pc_src, alu_op, alu_src_imm, shamt_reg,
        output mem_read, mem_write, reg_write, wb_mem, push, pop, illegal
    );

    modport slave (
        output Type, Func, Stop, zero, mem_ready, stack_full, stack_empty,
        input  state, ir_write, pc_write, pc_src, alu_op, alu_src_imm, shamt_reg,
        input  mem_read, mem_write, reg_write, wb_mem, push, pop, illegal
    );
endinterface

// File: rtl/control_classify.sv
// Combinational instruction classifier: Type/Func to legality, execution class and
// the ALU controls used during EXEC.
module control_classify
    import cpu_pkg::*;
(
    input  logic [1:0] type_i,
    input  logic [4:0] func_i,
    output logic       legal_o,
    output class_e     class_o,
    output alu_op_e    alu_op_o,
    output logic       alu_src_imm_o,
    output logic       shamt_reg_o
);

    always_comb begin
        legal_o       = 1'b0;
        class_o       = CL_ALU;
        alu_op_o      = ALU_AND;
        alu_src_imm_o = 1'b0;
        shamt_reg_o   = 1'b0;
        case (type_i)
            TYPE_R: begin
                legal_o = (func_i <= FR_CMP);
                case (func_i)
                    FR_ADD:         alu_op_o = ALU_ADD;
                    FR_SUB, FR_CMP: alu_op_o = ALU_SUB;
                    default:        alu_op_o = ALU_AND;
                endcase
            end
            TYPE_J: begin
                legal_o = (func_i <= FJ_JAL);
                class_o = (func_i == FJ_JAL) ? CL_JAL : CL_J;
            end
            TYPE_I: begin
                legal_o       = (func_i <= FI_BEQ);
                alu_src_imm_o = 1'b1;
                case (func_i)
                    FI_ADDI: alu_op_o = ALU_ADD;
                    FI_LW: begin
                        alu_op_o = ALU_ADD;
                        class_o  = CL_LW;
                    end
                    FI_SW: begin
                        alu_op_o = ALU_ADD;
                        class_o  = CL_SW;
                    end
                    FI_BEQ: begin
                        alu_op_o      = ALU_SUB;
                        alu_src_imm_o = 1'b0;
                        class_o       = CL_BEQ;
                    end
                    default: alu_op_o = ALU_AND;
                endcase
            end
            default: begin
                legal_o     = (func_i <= FS_SLRV);
                alu_op_o    = func_i[0] ? ALU_SLR : ALU_SLL;
                shamt_reg_o = func_i[1];
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT state.
// Strobes react to mem_ready/zero/stack status in the same cycle, so they are decoded from state.
module multicycle_control
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e  state_q, state_d;
    logic    legal;
    class_e  cls;
    alu_op_e cls_alu_op;
    logic    cls_imm;
    logic    cls_shamt;
    logic    last;

    control_classify u_classify (
        .type_i        (bus.Type),
        .func_i        (bus.Func),
        .legal_o       (legal),
        .class_o       (cls),
        .alu_op_o      (cls_alu_op),
        .alu_src_imm_o (cls_imm),
        .shamt_reg_o   (cls_shamt)
    );

    assign bus.state   = state_q;
    assign bus.illegal = (state_q == ST_FAULT);

    always_comb begin
        state_d         = state_q;
        last            = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = PC_PLUS4;
        bus.alu_op      = ALU_AND;
        bus.alu_src_imm = 1'b0;
        bus.shamt_reg   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.wb_mem      = 1'b0;
        bus.push        = 1'b0;
        bus.pop         = 1'b0;
        // Outputs are forced quiet while reset is held, even mid-access.
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!legal) begin
                        state_d = ST_FAULT;
                    end else if (cls == CL_J || cls == CL_JAL) begin
                        if (cls == CL_JAL && bus.stack_full) begin
                            state_d = ST_FAULT;
                        end else begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = PC_JUMP;
                            bus.push     = (cls == CL_JAL);
                            state_d      = ST_FETCH;
                        end
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    bus.alu_op      = cls_alu_op;
                    bus.alu_src_imm = cls_imm;
                    bus.shamt_reg   = cls_shamt;
                    case (cls)
                        CL_BEQ: begin
                            last = 1'b1;
                            if (bus.zero) begin
                                bus.pc_write = 1'b1;
                                bus.pc_src   = PC_BRANCH;
                            end
                            state_d = ST_FETCH;
                        end
                        CL_LW, CL_SW: state_d = ST_MEM;
                        default:      state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    bus.mem_read  = (cls == CL_LW);
                    bus.mem_write = (cls != CL_LW);
                    if (bus.mem_ready) begin
                        if (cls == CL_LW) begin
                            state_d = ST_WB;
                        end else begin
                            last    = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    bus.reg_write = 1'b1;
                    bus.wb_mem    = (cls == CL_LW);
                    last          = 1'b1;
                    state_d       = ST_FETCH;
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FAULT;
            endcase
            // Stop return overrides any branch; a pop on an empty stack kills every strobe.
            if (last && bus.Stop) begin
                if (bus.stack_empty) begin
                    state_d       = ST_FAULT;
                    bus.pc_write  = 1'b0;
                    bus.pc_src    = PC_PLUS4;
                    bus.reg_write = 1'b0;
                    bus.mem_read  = 1'b0;
                    bus.mem_write = 1'b0;
                end else begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_STACK;
                    bus.pop      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases then random instructions, every cycle
// compared against an instruction-level script of the expected control outputs.
module tb_multicycle_control;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int fetch_waits = -1;
    int mem_waits = -1;

    logic [2:0] e_state;
    logic [1:0] e_pcsrc;
    logic [2:0] e_alu;
    logic e_irw, e_pcw, e_imm, e_sh, e_mr, e_mw, e_rw, e_wbm, e_push, e_pop, e_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr_exp(input logic [2:0] st);
        e_state = st;
        e_pcsrc = 2'd0;
        e_alu   = 3'd0;
        {e_irw, e_pcw, e_imm, e_sh, e_mr, e_mw, e_rw, e_wbm, e_push, e_pop, e_ill} = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},       32'(bus.state),       32'(e_state));
        chk({tag, ".ir_write"},    32'(bus.ir_write),    32'(e_irw));
        chk({tag, ".pc_write"},    32'(bus.pc_write),    32'(e_pcw));
        chk({tag, ".pc_src"},      32'(bus.pc_src),      32'(e_pcsrc));
        chk({tag, ".alu_op"},      32'(bus.alu_op),      32'(e_alu));
        chk({tag, ".alu_src_imm"}, 32'(bus.alu_src_imm), 32'(e_imm));
        chk({tag, ".shamt_reg"},   32'(bus.shamt_reg),   32'(e_sh));
        chk({tag, ".mem_read"},    32'(bus.mem_read),    32'(e_mr));
        chk({tag, ".mem_write"},   32'(bus.mem_write),   32'(e_mw));
        chk({tag, ".reg_write"},   32'(bus.reg_write),   32'(e_rw));
        chk({tag, ".wb_mem"},      32'(bus.wb_mem),      32'(e_wbm));
        chk({tag, ".push"},        32'(bus.push),        32'(e_push));
        chk({tag, ".pop"},         32'(bus.pop),         32'(e_pop));
        chk({tag, ".illegal"},     32'(bus.illegal),     32'(e_ill));
    endtask

    task automatic step(input string tag, input logic rdy);
        @(negedge clk);
        bus.mem_ready = rdy;
        #1;
        check_all(tag);
    endtask

    function automatic logic ready_at(input int waits, input int k);
        if (waits >= 0) return (k >= waits);
        return ($urandom_range(0, 2) != 0) || (k >= 6);
    endfunction

    function automatic bit is_legal(input logic [1:0] t, input logic [4:0] f);
        case (t)
            2'd0:    return f <= 5'd3;
            2'd1:    return f <= 5'd1;
            2'd2:    return f <= 5'd4;
            default: return f <= 5'd3;
        endcase
    endfunction

    // Last cycle of a non-jump instruction: a Stop return, or a fault on an empty stack.
    task automatic completion(input logic stop, input logic se, output bit flt);
        flt = 1'b0;
        if (stop) begin
            if (se) begin
                {e_pcw, e_push, e_pop, e_rw, e_mr, e_mw} = '0;
                e_pcsrc = PC_PLUS4;
                flt = 1'b1;
            end else begin
                e_pcw = 1'b1;
                e_pcsrc = PC_STACK;
                e_pop = 1'b1;
            end
        end
    endtask

    task automatic run_instr(input logic [1:0] t, input logic [4:0] f, input logic stop,
                             input logic z, input logic sf, input logic se, output bit flt);
        logic rdy;
        int k;
        bit lw, sw, beq;
        flt = 1'b0;
        @(posedge clk);
        #1;
        bus.Type = t; bus.Func = f; bus.Stop = stop;
        bus.zero = z; bus.stack_full = sf; bus.stack_empty = se;
        lw  = (t == 2'd2) && (f == 5'd2);
        sw  = (t == 2'd2) && (f == 5'd3);
        beq = (t == 2'd2) && (f == 5'd4);
        k = 0;
        do begin
            rdy = ready_at(fetch_waits, k);
            clr_exp(ST_FETCH);
            e_mr = 1'b1;
            if (rdy) begin e_irw = 1'b1; e_pcw = 1'b1; end
            step("fetch", rdy);
            k++;
        end while (!rdy);
        clr_exp(ST_DECODE);
        if (!is_legal(t, f)) begin
            step("decode_bad", 1'($urandom_range(0, 1)));
            flt = 1'b1;
            return;
        end
        if (t == 2'd1) begin
            if (f == 5'd1 && sf) flt = 1'b1;
            else begin
                e_pcw = 1'b1;
                e_pcsrc = PC_JUMP;
                e_push = (f == 5'd1);
            end
            step("jump", 1'($urandom_range(0, 1)));
            return;
        end
        step("decode", 1'($urandom_range(0, 1)));
        clr_exp(ST_EXEC);
        case (t)
            2'd0: e_alu = (f == 5'd0) ? ALU_AND : (f == 5'd1) ? ALU_ADD : ALU_SUB;
            2'd2: begin
                e_alu = (f == 5'd0) ? ALU_AND : (f == 5'd4) ? ALU_SUB : ALU_ADD;
                e_imm = (f != 5'd4);
            end
            default: begin
                e_alu = f[0] ? ALU_SLR : ALU_SLL;
                e_sh  = f[1];
            end
        endcase
        if (beq) begin
            if (z) begin e_pcw = 1'b1; e_pcsrc = PC_BRANCH; end
            completion(stop, se, flt);
            step("beq", 1'($urandom_range(0, 1)));
            return;
        end
        step("exec", 1'($urandom_range(0, 1)));
        if (lw || sw) begin
            k = 0;
            do begin
                rdy = ready_at(mem_waits, k);
                clr_exp(ST_MEM);
                e_mr = lw;
                e_mw = sw;
                if (rdy && sw) completion(stop, se, flt);
                step("mem", rdy);
                k++;
            end while (!rdy);
            if (sw) return;
        end
        clr_exp(ST_WB);
        e_rw = 1'b1;
        e_wbm = lw;
        completion(stop, se, flt);
        step("wb", 1'($urandom_range(0, 1)));
    endtask

    task automatic fault_phase();
        repeat (3) begin
            clr_exp(ST_FAULT);
            e_ill = 1'b1;
            step("fault", 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        clr_exp(ST_FETCH);
        check_all("reset");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        bit flt;
        logic [1:0] t;
        logic [4:0] f;
        reset = 1'b1;
        bus.Type = 2'd0; bus.Func = 5'd0; bus.Stop = 1'b0; bus.zero = 1'b0;
        bus.mem_ready = 1'b0; bus.stack_full = 1'b0; bus.stack_empty = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fetch stalled on memory, then reset lands mid-access.
        clr_exp(ST_FETCH);
        e_mr = 1'b1;
        step("fetch_wait", 1'b0);
        step("fetch_wait", 1'b0);
        do_reset();

        fetch_waits = 0; mem_waits = 0;
        run_instr(2'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, flt);     // ADD
        mem_waits = 2;
        run_instr(2'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, flt);     // LW, 2 waits
        mem_waits = 0;
        run_instr(2'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, flt);     // SW
        run_instr(2'd2, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, flt);     // BEQ taken
        run_instr(2'd2, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, flt);     // BEQ not taken
        run_instr(2'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, flt);     // BEQ + Stop
        run_instr(2'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, flt);     // SLRV
        run_instr(2'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, flt);     // JAL, Stop ignored
        run_instr(2'd1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, flt);     // JAL, stack full
        fault_phase();
        do_reset();
        run_instr(2'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, flt);     // SUB + Stop, stack empty
        fault_phase();
        do_reset();
        run_instr(2'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, flt);     // undefined
        fault_phase();
        do_reset();

        fetch_waits = -1; mem_waits = -1;
        repeat (300) begin
            t = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            run_instr(t, f, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0), flt);
            if (flt) begin
                fault_phase();
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the 32-bit processor. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every datapath enable and mux select. Its inputs are the Type/Func/Stop fields produced by the instruction decoder, plus the ALU zero flag, memory ready and stack status. It sits between the decoder and the datapath: PC, register file, ALU, memory and return stack.

## Interface
Parameters:
- none (encodings fixed in `cpu_pkg`)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `Type`  in  2  instruction type: 00 R, 01 J, 10 I, 11 S
- `Func`  in  5  function code
- `Stop`  in  1  instruction Stop bit (return via stack pop at completion)
- `zero`  in  1  ALU zero flag, valid in EXEC
- `mem_ready`  in  1  memory handshake; access completes in the cycle it is 1
- `stack_full`, `stack_empty`  in  1 each  return-stack status
- `state`  out  3  current FSM state (debug)
- `ir_write`, `pc_write`  out  1 each  IR load / PC load strobes
- `pc_src`  out  2  0 PC+4, 1 branch target, 2 jump target, 3 stack top
- `alu_op`  out  3  0 AND, 1 ADD, 2 SUB, 3 SLL, 4 SLR
- `alu_src_imm`  out  1  ALU B = sign-extended immediate
- `shamt_reg`  out  1  shift amount from Rs2 (1) or SA field (0)
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `reg_write`  out  1  register-file write
- `wb_mem`  out  1  write-back data from memory (1) or ALU (0)
- `push`, `pop`  out  1 each  return-stack strobes
- `illegal`  out  1  sticky fault flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT.
- FETCH:
  - `mem_read`=1 until `mem_ready`.
  - In the `mem_ready` cycle: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify Type/Func.
  - Undefined code goes to FAULT.
  - J (Func 0 J, 1 JAL): `pc_write`=1, `pc_src`=2; JAL also asserts `push`; then FETCH. Stop is ignored for J-type.
  - All other types go to EXEC.
- Legal codes:
  - R: 0 AND, 1 ADD, 2 SUB, 3 CMP
  - I: 0 ANDI, 1 ADDI, 2 LW, 3 SW, 4 BEQ
  - S: 0 SLL, 1 SLR, 2 SLLV, 3 SLRV
- EXEC: `alu_op`/`alu_src_imm`/`shamt_reg` are held for the whole EXEC cycle.
  - R and S go to WB. I ALU ops go to WB.
  - LW and SW go to MEM.
  - BEQ: `alu_op`=SUB. If `zero`=1, `pc_write`=1 and `pc_src`=1. Then FETCH.
- MEM: `mem_read` (LW) or `mem_write` (SW) is held until `mem_ready`.
  - LW then goes to WB.
  - SW completes and goes to FETCH.
- WB: `reg_write`=1 for one cycle, `wb_mem`=1 for LW, then FETCH.
  - CMP writes its flag result through the ALU path like other R ops.
- Completion cycle = last cycle before returning to FETCH.
  - If Stop=1 (non-J): `pc_write`=1, `pc_src`=3, `pop`=1 in that cycle.
  - This overrides a taken BEQ.
- Stack faults:
  - `push` requested with `stack_full`=1, or `pop` requested with `stack_empty`=1, goes to FAULT.
  - The faulting cycle asserts no strobe: no `pc_write`, `push`, `pop` or `reg_write`.
- FAULT: `illegal`=1, all strobes 0. Only `reset` exits.
- Reset clears the FSM immediately to FETCH, including mid-access.

## Timing
- Reset values:
  - `state`=FETCH.
  - Every strobe 0.
  - `pc_src`=0, `alu_op`=0, all selects 0, `illegal`=0.
- Strobes are asserted for exactly one cycle, except `mem_read`/`mem_write`, which hold until `mem_ready`.
- Latency with zero wait states:
  - J/JAL: 2 cycles
  - BEQ: 3 cycles
  - SW: 4 cycles
  - R, S, ANDI, ADDI: 4 cycles
  - LW: 5 cycles
- Each memory wait cycle adds one cycle.
- Type/Func/Stop are sampled only in DECODE and later states; they come from the IR and are stable after FETCH.
- `zero` is sampled only in EXEC.

## Structure
- `cpu_pkg` holds:
  - state enum
  - Type codes
  - per-type Func codes
  - `pc_src` and `alu_op` encodings
- One sub-module, `control_classify`, is combinational: Type/Func → {legal, class ALU/LW/SW/BEQ/J/JAL, alu_op, alu_src_imm, shamt_reg}.
- The top holds the FSM and strobe logic.

## Test plan
- Reset during FETCH with `mem_ready`=0 → state FETCH, all outputs 0 in the same cycle; first instruction fetched after release.
- ADD (Type 00, Func 1), `mem_ready` always 1 → `ir_write`/`pc_write` in cycle 1, WB `reg_write` in cycle 4, `alu_op`=1 in EXEC.
- LW (Type 10, Func 2) with 2 memory wait states in MEM → `mem_read` held 3 cycles; WB with `wb_mem`=1 in cycle 7.
- BEQ: `zero`=1 → `pc_src`=1, `pc_write` in cycle 3. `zero`=0 → no `pc_write` after FETCH. BEQ with Stop=1 → `pc_src`=3, `pop`=1.
- JAL with `stack_full`=0 → `push`=1, `pc_src`=2 in cycle 2. JAL with `stack_full`=1 → FAULT, `illegal`=1, no `push`.
- Undefined code (Type 11, Func 7) → FAULT after DECODE; `illegal` held until reset.
